// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised rx, mid-bit sampling of 8N1 frames, one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err_o.
module uart_rx #(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_pin,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       busy_o,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       parity_err_o
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t          r_state, w_state_nxt;
   logic            r_sync1, r_sync2, r_prev;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [2:0]      r_idx, w_idx_nxt;
   logic [7:0]      r_shift, w_shift_nxt;
   logic [7:0]      r_data, w_data_nxt;
   logic            r_valid, w_valid_nxt;
   logic            r_ferr, w_ferr_nxt;
   logic            r_ovr, w_ovr_nxt;
   logic            w_good;
   logic            w_half_done, w_bit_done;
`ifdef UART_RX_PARITY_EN
   logic            r_par, w_par_nxt;
   logic            r_perr, w_perr_nxt;
`endif

   assign w_half_done = (r_cnt == CW'(HALF_BIT - 1));
   assign w_bit_done  = (r_cnt == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par   <= 1'b0;
         r_perr  <= 1'b0;
`endif
      end else begin
         r_sync1 <= rx_pin;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
         r_ferr  <= w_ferr_nxt;
         r_ovr   <= w_ovr_nxt;
`ifdef UART_RX_PARITY_EN
         r_par   <= w_par_nxt;
         r_perr  <= w_perr_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CW'(1);
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_data_nxt  = r_data;
      w_valid_nxt = r_valid;
      w_ferr_nxt  = 1'b0;
      w_ovr_nxt   = 1'b0;
      w_good      = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_nxt   = r_par;
      w_perr_nxt  = 1'b0;
`endif
      if (r_valid && ready_i)
         w_valid_nxt = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            // Edge-triggered so a held-low (break) line cannot retrigger.
            if (r_prev && !r_sync2)
               w_state_nxt = S_START;
         end
         S_START: begin
            if (w_half_done) begin
               w_cnt_nxt = '0;
               if (r_sync2) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_DATA;
                  w_idx_nxt   = '0;
               end
            end
         end
         S_DATA: begin
            if (w_bit_done) begin
               w_cnt_nxt          = '0;
               w_shift_nxt[r_idx] = r_sync2;
               if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_bit_done) begin
               w_cnt_nxt   = '0;
               w_par_nxt   = r_sync2;
               w_state_nxt = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (w_bit_done) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_IDLE;
               if (!r_sync2)
                  w_ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
               else if ((^r_shift) ^ r_par)
                  w_perr_nxt = 1'b1;
`endif
               else
                  w_good = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      // A byte consumed this cycle frees the holding register for the new one.
      if (w_good) begin
         if (!r_valid || ready_i) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
         end else begin
            w_ovr_nxt = 1'b1;
         end
      end
   end

   assign data_o      = r_data;
   assign valid_o     = r_valid;
   assign busy_o      = (r_state != S_IDLE);
   assign frame_err_o = r_ferr;
   assign overrun_o   = r_ovr;
`ifdef UART_RX_PARITY_EN
   assign parity_err_o = r_perr;
`else
   assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: driver queues expected bytes/pulses, monitor checks handshakes and pulses.
// Also exercises the 8E1 variant when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

   localparam int unsigned CLK_FREQ = 6400000;
   localparam int unsigned BAUD     = 100000;
   localparam int unsigned CPB      = CLK_FREQ / BAUD;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_pin = 1'b1;
   logic       ready_i = 1'b1;
   logic [7:0] data_o;
   logic       valid_o, busy_o, frame_err_o, overrun_o, parity_err_o;

   always #5 clk = ~clk;

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
      .clk(clk), .rst_n(rst_n), .rx_pin(rx_pin), .data_o(data_o), .valid_o(valid_o),
      .ready_i(ready_i), .busy_o(busy_o), .frame_err_o(frame_err_o),
      .overrun_o(overrun_o), .parity_err_o(parity_err_o)
   );

   int unsigned n_checks = 0, n_pass = 0;
   logic [7:0]  exp_q[$];
   int unsigned exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
   int unsigned obs_ferr = 0, obs_ovr = 0, obs_perr = 0, obs_xfer = 0;
   logic        m_full = 1'b0;
   logic [7:0]  m_last = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_frame_err_count"}, obs_ferr, exp_ferr);
      check({tag, "_overrun_count"}, obs_ovr, exp_ovr);
      check({tag, "_parity_err_count"}, obs_perr, exp_perr);
   endtask

   // Monitor: every accepted handshake must match the oldest queued byte.
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_err_o)  obs_ferr++;
         if (overrun_o)    obs_ovr++;
         if (parity_err_o) obs_perr++;
         if (valid_o && ready_i) begin
            obs_xfer++;
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL xfer_unexpected: got %0h expected no byte", data_o);
            end else begin
               check("xfer_data", {24'h0, data_o}, {24'h0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic bit_time(input logic v);
      rx_pin = v;
      repeat (CPB) @(posedge clk);
   endtask

   // Reference model: a frame is good when stop=1 (and parity right); a good frame
   // is kept only if the single holding slot is free, else it is an overrun.
   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_good);
      logic good;
      good = stop_b;
`ifdef UART_RX_PARITY_EN
      good = stop_b & par_good;
`endif
      if (!stop_b)     exp_ferr++;
      else if (!good)  exp_perr++;
      else if (m_full) exp_ovr++;
      else begin
         exp_q.push_back(d);
         m_last = d;
         if (!ready_i) m_full = 1'b1;
      end
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
      bit_time((^d) ^ ~par_good);
`endif
      bit_time(stop_b);
      rx_pin = 1'b1;
   endtask

   task automatic idle(input int unsigned cycles);
      rx_pin = 1'b1;
      repeat (cycles) @(posedge clk);
   endtask

   initial begin
      int unsigned xfer0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_data", {24'h0, data_o}, 32'h0);
      check("rst_valid", valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_frame_err", frame_err_o, 0);
      check("rst_overrun", overrun_o, 0);
      check("rst_parity_err", parity_err_o, 0);
      rst_n = 1'b1;
      idle(2 * CPB);

      // Back-to-back frames with ready held high.
      xfer0 = obs_xfer;
      send_frame(8'h55, 1'b1, 1'b1);
      send_frame(8'hA5, 1'b1, 1'b1);
      idle(2 * CPB);
      check("b2b_xfers", obs_xfer - xfer0, 2);
      check_counts("b2b");

      // Short low glitch: false start, no output.
      xfer0 = obs_xfer;
      rx_pin = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("glitch_busy_high", busy_o, 1);
      rx_pin = 1'b1;
      repeat (30) @(posedge clk);
      @(negedge clk);
      check("glitch_busy_low", busy_o, 0);
      idle(CPB);
      check("glitch_xfers", obs_xfer - xfer0, 0);
      check_counts("glitch");

      // Bad stop bit, then a clean frame.
      send_frame(8'h3C, 1'b0, 1'b1);
      idle(CPB);
      @(negedge clk);
      check("ferr_valid", valid_o, 0);
      check("ferr_data_kept", {24'h0, data_o}, {24'h0, m_last});
      check_counts("ferr");
      send_frame(8'h12, 1'b1, 1'b1);
      idle(2 * CPB);
      check("ferr_recover_queue", exp_q.size(), 0);

      // Overrun with the consumer stalled.
      ready_i = 1'b0;
      send_frame(8'h11, 1'b1, 1'b1);
      send_frame(8'h22, 1'b1, 1'b1);
      idle(CPB);
      @(negedge clk);
      check("ovr_valid", valid_o, 1);
      check("ovr_data_held", {24'h0, data_o}, {24'h0, m_last});
      check_counts("ovr");
      ready_i = 1'b1;
      m_full = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("ovr_drain_valid", valid_o, 0);
      check("ovr_drain_queue", exp_q.size(), 0);

      // Reset during data bit 4 of 0x77.
      bit_time(1'b0);
      for (int i = 0; i < 4; i++) bit_time(1'b1 & (8'h77 >> i));
      rx_pin = 1'b1;
      repeat (CPB / 3) @(posedge clk);
      rst_n = 1'b0;
      m_full = 1'b0;
      m_last = 8'h00;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("midrst_data", {24'h0, data_o}, 32'h0);
      check("midrst_valid", valid_o, 0);
      check("midrst_busy", busy_o, 0);
      rst_n = 1'b1;
      idle(2 * CPB);
      send_frame(8'h81, 1'b1, 1'b1);
      idle(2 * CPB);
      check("midrst_recover_queue", exp_q.size(), 0);
      check_counts("midrst");

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0);
      idle(CPB);
      @(negedge clk);
      check("perr_valid", valid_o, 0);
      check_counts("perr");
      send_frame(8'h07, 1'b1, 1'b1);
      idle(CPB);
      check("par_ok_queue", exp_q.size(), 0);
      check("par_ok_data", {24'h0, data_o}, 32'h07);
`endif

      // Randomized frames: bad stop/parity occasionally, random inter-frame gaps.
      for (int n = 0; n < 24; n++) begin
         logic [7:0]  d;
         logic        stop_b, par_good;
         int unsigned gap;
         d        = 8'($urandom);
         stop_b   = ($urandom_range(0, 7) != 0);
         par_good = ($urandom_range(0, 7) != 0);
         send_frame(d, stop_b, par_good);
         gap = $urandom_range(0, CPB);
         if (!stop_b && gap < CPB) gap = CPB;
         if (gap > 0) idle(gap);
      end
      idle(3 * CPB);
      check("final_queue_empty", exp_q.size(), 0);
      check_counts("final");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
